gray_sync_decoder: RTL

- Downstream consumer of the gray counter's gray-coded output.
- Resynchronises the gray code through a flop chain, since the source may be asynchronous to this clock. Decodes it to binary and tracks each step.
- Flags steps that are backward or non-adjacent, and keeps a saturating error count.
- Sits between a gray-coded pointer/position source and the binary logic that consumes it.

---
 rtl/gray_sync_decoder_if.sv | 37 +++
 rtl/gray_sync_decoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gray_sync_decoder_if.sv
// gray_sync_decoder_if
//   Bundles the signals exchanged between the gray-code decoder and its
//   surroundings. The decoder takes the slave view. The driving or observing
//   environment takes the master view.
//   gray_in   : gray-coded value from the upstream counter (master -> slave)
//   clear_err : synchronous clear of err_count             (master -> slave)
//   gray_sync : last synchroniser stage                    (slave -> master)
//   bin_out   : registered binary decode                   (slave -> master)
//   advance   : one-cycle pulse, +1 step accepted          (slave -> master)
//   dir_err   : one-cycle pulse, -1 step seen              (slave -> master)
//   jump_err  : one-cycle pulse, any other change          (slave -> master)
//   err_count : saturating error count                     (slave -> master)
//   locked    : tracking has started                       (slave -> master)
interface gray_sync_decoder_if #(
  parameter int data_width = 4,
  parameter int err_width  = 8
);
  logic [data_width-1:0] gray_in;
  logic                  clear_err;
  logic [data_width-1:0] gray_sync;
  logic [data_width-1:0] bin_out;
  logic                  advance;
  logic                  dir_err;
  logic                  jump_err;
  logic [err_width-1:0]  err_count;
  logic                  locked;

  modport master (
    output gray_in, clear_err,
    input  gray_sync, bin_out, advance, dir_err, jump_err, err_count, locked
  );

  modport slave (
    input  gray_in, clear_err,
    output gray_sync, bin_out, advance, dir_err, jump_err, err_count, locked
  );
endinterface

// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
//   Consumes a gray-coded pointer or position that may be asynchronous to clk.
//   The value first passes through a flop chain. It is then decoded to binary,
//   and every step it takes is tracked. A +1 step raises advance. A -1 step
//   raises dir_err. Any other change raises jump_err. Error pulses are
//   counted in a saturating counter.
//   Ports:
//     clk    : sole clock, rising edge
//     resetn : asynchronous reset, active HIGH despite the name
//     bus    : gray_sync_decoder_if.slave. It carries gray_in and clear_err
//              in, and gray_sync, bin_out, advance, dir_err, jump_err,
//              err_count and locked out.
module gray_sync_decoder #(
  parameter int data_width  = 4,
  parameter int sync_stages = 2,
  parameter int err_width   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  gray_sync_decoder_if.slave bus
);

  localparam int FCW = $clog2(sync_stages);

  typedef enum logic {FILL = 1'b0, TRACK = 1'b1} state_t;

  generate
    if (sync_stages < 2 || sync_stages > 4) begin : g_bad_stages
      $error("gray_sync_decoder: sync_stages must be in 2..4");
    end
  endgenerate

  function automatic logic [data_width-1:0] gray2bin(input logic [data_width-1:0] g);
    logic [data_width-1:0] b;
    b[data_width-1] = g[data_width-1];
    for (int i = data_width-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // ---------------------------------------------------------------- sync
  logic [sync_stages-1:0][data_width-1:0] sync_q;
  logic [data_width-1:0] gray_sync;
  logic [data_width-1:0] lock_src;
  logic [data_width-1:0] dec_sync;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) sync_q <= '0;
    else        sync_q <= {sync_q[sync_stages-2:0], bus.gray_in};
  end

  assign gray_sync = sync_q[sync_stages-1];
  // The lock edge loads the value that gray_sync takes on that same edge.
  // On release the chain still holds the reset zeros. Lock therefore
  // completes on edge sync_stages, and the first TRACK compare sees the
  // post-reset input rather than a spurious 0 -> input step.
  assign lock_src  = sync_q[sync_stages-2];
  assign dec_sync  = gray2bin(gray_sync);

  // ---------------------------------------------------------------- fsm
  state_t               state_q, state_d;
  logic [FCW-1:0]       fill_cnt_q;
  logic                 fill_done;

  logic [data_width-1:0] prev_q, bin_q, step_d;
  logic                  adv_q, dir_q, jmp_q, locked_q;
  logic                  adv_d, dir_d, jmp_d, load_lock, upd;
  logic [err_width-1:0]  err_q;

  assign fill_done = (state_q == FILL) && (fill_cnt_q == FCW'(sync_stages-1));
  // Step size modulo 2^W. Wrap 2^W-1 -> 0 lands on 1, which is a legal advance.
  assign step_d    = dec_sync - bin_q;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == FILL) fill_cnt_q <= fill_cnt_q + FCW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (fill_done) state_d = TRACK;
      TRACK:   state_d = TRACK;   // left only through reset
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    load_lock = 1'b0;
    upd       = 1'b0;
    adv_d     = 1'b0;
    dir_d     = 1'b0;
    jmp_d     = 1'b0;
    case (state_q)
      FILL: load_lock = fill_done;
      TRACK: begin
        if (gray_sync != prev_q) begin
          upd = 1'b1;
          if (step_d == data_width'(1)) adv_d = 1'b1;
          else if (step_d == '1)        dir_d = 1'b1;
          else                          jmp_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      prev_q   <= '0;
      bin_q    <= '0;
      locked_q <= 1'b0;
      adv_q    <= 1'b0;
      dir_q    <= 1'b0;
      jmp_q    <= 1'b0;
    end else begin
      adv_q <= adv_d;
      dir_q <= dir_d;
      jmp_q <= jmp_d;
      if (load_lock) begin
        prev_q   <= lock_src;
        bin_q    <= gray2bin(lock_src);
        locked_q <= 1'b1;
      end else if (upd) begin
        // Every change resyncs, so one bad step costs exactly one error.
        prev_q <= gray_sync;
        bin_q  <= dec_sync;
      end
    end
  end

  // A clear that coincides with a new error leaves that error counted.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn)                      err_q <= '0;
    else if (bus.clear_err)          err_q <= (dir_d || jmp_d) ? err_width'(1) : '0;
    else if ((dir_d || jmp_d) && (err_q != '1)) err_q <= err_q + err_width'(1);
  end

  assign bus.gray_sync = gray_sync;
  assign bus.bin_out   = bin_q;
  assign bus.advance   = adv_q;
  assign bus.dir_err   = dir_q;
  assign bus.jump_err  = jmp_q;
  assign bus.err_count = err_q;
  assign bus.locked    = locked_q;

endmodule
